dmem_stall_mem: RTL and testbench

DMEM_STALL_MEM -- requirements
Module: dmem_stall_mem

---
 rtl/dmem_stall_mem.sv | 155 +++++++++++++++
 tb/tb_dmem_stall_mem.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_stall_mem.sv
// rtl/dmem_stall_mem.sv - data memory with a fixed-latency stall handshake toward the processor pipeline
module dmem_stall_mem #(
    parameter int DEPTH_WORDS = 64,
    parameter int READ_LAT    = 2,
    parameter int WRITE_LAT   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_write_data,
    input  logic        dmem_write,
    input  logic        dmem_read,
    output logic [31:0] dmem_read_data,
    output logic        dmem_stall,
    output logic        dmem_done,
    output logic        err_misalign
);

    localparam int AW      = $clog2(DEPTH_WORDS);
    localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_next_cnt;
    logic [AW+1:0]   r_addr;
    logic [31:0]     r_wdata;
    logic            r_is_write;
    logic [31:0]     r_mem [DEPTH_WORDS];

    logic            w_req;
    logic            w_sample;
    logic [CW-1:0]   w_lat;
    logic            w_enter_done;
    logic [AW+1:0]   w_cur_addr;
    logic [31:0]     w_cur_wdata;
    logic            w_cur_is_write;
    logic            w_aligned;
    logic [AW-1:0]   w_idx;
    logic            w_mem_we;
    logic            w_unused_addr;

    assign w_req    = dmem_read | dmem_write;
    assign w_sample = (r_state == S_IDLE) && w_req;

    // Store wins when both strobes are high.
    assign w_lat = dmem_write ? CW'(WRITE_LAT) : CW'(READ_LAT);

    // A single-cycle access completes on its sampling edge, so the live inputs
    // are used then; otherwise the copies captured in IDLE drive the access.
    assign w_cur_addr     = w_sample ? dmem_addr[AW+1:0] : r_addr;
    assign w_cur_wdata    = w_sample ? dmem_write_data   : r_wdata;
    assign w_cur_is_write = w_sample ? dmem_write        : r_is_write;
    assign w_aligned      = (w_cur_addr[1:0] == 2'b00);
    assign w_idx          = w_cur_addr[AW+1:2];

    // Upper address bits are deliberately dropped so addresses wrap.
    assign w_unused_addr = &{1'b0, dmem_addr[31:AW+2]};

    // An edge taken while reset is low must never commit a store.
    assign w_mem_we = reset & w_enter_done & w_cur_is_write & w_aligned;

    assign dmem_done  = (r_state == S_DONE);
    assign dmem_stall = w_req & (r_state != S_DONE);

    // Next-state and counter logic; DONE entry is flagged for commit/load capture.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_enter_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_next_cnt = w_lat;
                    if (w_lat == CW'(1)) begin
                        w_next_state = S_DONE;
                        w_enter_done = 1'b1;
                    end else begin
                        w_next_state = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                w_next_cnt = r_cnt - CW'(1);
                if (r_cnt == CW'(2)) begin
                    w_next_state = S_DONE;
                    w_enter_done = 1'b1;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State and stall counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Capture the request in IDLE; later input changes are ignored until the access ends.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_is_write <= 1'b0;
        end else if (w_sample) begin
            r_addr     <= dmem_addr[AW+1:0];
            r_wdata    <= dmem_write_data;
            r_is_write <= dmem_write;
        end
    end

    // Load result is registered on DONE entry; misaligned loads return zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dmem_read_data <= '0;
        end else if (w_enter_done && !w_cur_is_write) begin
            dmem_read_data <= w_aligned ? r_mem[w_idx] : 32'h0;
        end
    end

    // Sticky misalignment flag, set when a misaligned access completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_misalign <= 1'b0;
        end else if (w_enter_done && !w_aligned) begin
            err_misalign <= 1'b1;
        end
    end

    // Memory array is not reset; aligned stores commit only on DONE entry.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= w_cur_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_stall_mem.sv
// tb/tb_dmem_stall_mem.sv - scoreboard testbench for dmem_stall_mem
module tb_dmem_stall_mem;

    localparam int RD = 3;
    localparam int WR = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_write_data;
    logic        dmem_write;
    logic        dmem_read;
    logic [31:0] dmem_read_data;
    logic        dmem_stall;
    logic        dmem_done;
    logic        err_misalign;

    int n_vec  = 0;
    int n_fail = 0;
    int stall_cnt = 0;

    logic [31:0] q_rdata [$];
    logic        q_err   [$];
    int          q_stall [$];

    dmem_stall_mem #(
        .DEPTH_WORDS(64),
        .READ_LAT   (RD),
        .WRITE_LAT  (WR)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .dmem_addr      (dmem_addr),
        .dmem_write_data(dmem_write_data),
        .dmem_write     (dmem_write),
        .dmem_read      (dmem_read),
        .dmem_read_data (dmem_read_data),
        .dmem_stall     (dmem_stall),
        .dmem_done      (dmem_done),
        .err_misalign   (err_misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: counts stall cycles per access and checks each completion against the queue.
    always @(negedge clk) begin
        logic [31:0] e_rd;
        logic        e_err;
        int          e_st;
        if (!reset) begin
            stall_cnt = 0;
        end else begin
            if (dmem_stall === 1'b1) stall_cnt++;
            if (dmem_done === 1'b1) begin
                if (q_rdata.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done with empty queue at %0t", $time);
                end else begin
                    e_rd  = q_rdata.pop_front();
                    e_err = q_err.pop_front();
                    e_st  = q_stall.pop_front();
                    chk("read_data", dmem_read_data, e_rd);
                    chk("err_misalign", {31'd0, err_misalign}, {31'd0, e_err});
                    chk("stall_cycles", stall_cnt, e_st);
                end
                stall_cnt = 0;
            end
        end
    end

    // mode 0: hold request; 1: drop request after sampling; 2: change addr/data after sampling
    task automatic access(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [31:0] data, input int mode,
                          input logic [31:0] exp_rd, input logic exp_err, input int exp_stall);
        logic seen;
        q_rdata.push_back(exp_rd);
        q_err.push_back(exp_err);
        q_stall.push_back(exp_stall);
        @(posedge clk);
        #1;
        dmem_write      = wr;
        dmem_read       = rd;
        dmem_addr       = addr;
        dmem_write_data = data;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (dmem_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (i == 0 && mode != 0) begin
                @(posedge clk);
                #1;
                if (mode == 1) begin
                    dmem_write      = 1'b0;
                    dmem_read       = 1'b0;
                    dmem_addr       = 32'hFFFF_FFF0;
                    dmem_write_data = 32'hBAD0_BAD0;
                end else begin
                    dmem_addr       = addr ^ 32'h4;
                    dmem_write_data = ~data;
                end
            end
        end
        if (!seen) begin
            n_vec++;
            n_fail++;
            $display("FAIL done_timeout: got no done expected done for addr %h", addr);
        end
    endtask

    task automatic go_idle();
        @(posedge clk);
        #1;
        dmem_write = 1'b0;
        dmem_read  = 1'b0;
    endtask

    initial begin
        reset           = 1'b0;
        dmem_addr       = '0;
        dmem_write_data = '0;
        dmem_write      = 1'b0;
        dmem_read       = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_done", {31'd0, dmem_done}, 32'd0);
        chk("rst_read_data", dmem_read_data, 32'd0);
        chk("rst_err", {31'd0, err_misalign}, 32'd0);
        chk("rst_stall_noreq", {31'd0, dmem_stall}, 32'd0);
        dmem_read = 1'b1;
        #1;
        chk("rst_stall_req", {31'd0, dmem_stall}, 32'd1);
        dmem_read = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;

        access(1'b1, 1'b0, 32'd84, 32'd7, 0, 32'd0, 1'b0, WR);
        access(1'b0, 1'b1, 32'd84, 32'd0, 0, 32'd7, 1'b0, RD);
        access(1'b1, 1'b0, 32'd80, 32'h1111_1111, 0, 32'd7, 1'b0, WR);
        access(1'b0, 1'b1, 32'd80, 32'd0, 0, 32'h1111_1111, 1'b0, RD);
        access(1'b1, 1'b1, 32'd80, 32'hDEAD_BEEF, 0, 32'h1111_1111, 1'b0, WR);
        access(1'b0, 1'b1, 32'd80, 32'd0, 0, 32'hDEAD_BEEF, 1'b0, RD);
        access(1'b1, 1'b0, 32'd82, 32'h55, 0, 32'hDEAD_BEEF, 1'b1, WR);
        access(1'b0, 1'b1, 32'd80, 32'd0, 0, 32'hDEAD_BEEF, 1'b1, RD);
        access(1'b0, 1'b1, 32'd82, 32'd0, 0, 32'd0, 1'b1, RD);
        access(1'b1, 1'b0, 32'd256, 32'd5, 0, 32'd0, 1'b1, WR);
        access(1'b0, 1'b1, 32'd0, 32'd0, 0, 32'd5, 1'b1, RD);
        access(1'b1, 1'b0, 32'h1FC, 32'h1234_5678, 0, 32'd5, 1'b1, WR);
        access(1'b0, 1'b1, 32'hFC, 32'd0, 0, 32'h1234_5678, 1'b1, RD);
        access(1'b1, 1'b0, 32'd88, 32'hA5A5_A5A5, 1, 32'h1234_5678, 1'b1, 1);
        access(1'b0, 1'b1, 32'd88, 32'd0, 2, 32'hA5A5_A5A5, 1'b1, RD);
        access(1'b0, 1'b1, 32'd84, 32'd0, 1, 32'd7, 1'b1, 1);
        go_idle();

        // Abort a store of 9 to 84 while BUSY.
        @(posedge clk);
        #1;
        dmem_write      = 1'b1;
        dmem_addr       = 32'd84;
        dmem_write_data = 32'd9;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_done", {31'd0, dmem_done}, 32'd0);
        chk("abort_read_data", dmem_read_data, 32'd0);
        chk("abort_err", {31'd0, err_misalign}, 32'd0);
        chk("abort_stall", {31'd0, dmem_stall}, 32'd1);
        dmem_write = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        access(1'b0, 1'b1, 32'd84, 32'd0, 0, 32'd7, 1'b0, RD);
        go_idle();

        repeat (4) @(negedge clk);
        chk("queue_drained", q_rdata.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
